// File: rtl/sdram_read_arbiter_pkg.sv
// Shared definitions for the sdram0 read path.
// Holds the default Avalon widths used by the arbiter and its bus
// interface, plus the arbiter FSM state encoding.
package rush3d_sdram_pkg;

    localparam int ADDR_WIDTH  = 29;
    localparam int DATA_WIDTH  = 64;
    localparam int BURST_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sdram_read_arbiter_if.sv
// Bus bundle for sdram_read_arbiter.
// Carries both requester read ports (s0 = scan-out, s1 = renderer fetch)
// and the single sdram0 Avalon read master.
//   slave  : arbiter view (takes requester commands and sdram responses)
//   master : environment view (drives requester commands and sdram responses)
interface sdram_read_arbiter_if #(
    parameter int ADDR_WIDTH  = rush3d_sdram_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH  = rush3d_sdram_pkg::DATA_WIDTH,
    parameter int BURST_WIDTH = rush3d_sdram_pkg::BURST_WIDTH
);
    logic                   s0_read;
    logic [ADDR_WIDTH-1:0]  s0_address;
    logic [BURST_WIDTH-1:0] s0_burstcount;
    logic                   s0_waitrequest;
    logic [DATA_WIDTH-1:0]  s0_readdata;
    logic                   s0_readdatavalid;

    logic                   s1_read;
    logic [ADDR_WIDTH-1:0]  s1_address;
    logic [BURST_WIDTH-1:0] s1_burstcount;
    logic                   s1_waitrequest;
    logic [DATA_WIDTH-1:0]  s1_readdata;
    logic                   s1_readdatavalid;

    logic [ADDR_WIDTH-1:0]  m_address;
    logic [BURST_WIDTH-1:0] m_burstcount;
    logic                   m_read;
    logic                   m_waitrequest;
    logic [DATA_WIDTH-1:0]  m_readdata;
    logic                   m_readdatavalid;

    modport slave (
        input  s0_read, s0_address, s0_burstcount,
        input  s1_read, s1_address, s1_burstcount,
        input  m_waitrequest, m_readdata, m_readdatavalid,
        output s0_waitrequest, s0_readdata, s0_readdatavalid,
        output s1_waitrequest, s1_readdata, s1_readdatavalid,
        output m_address, m_burstcount, m_read
    );

    modport master (
        output s0_read, s0_address, s0_burstcount,
        output s1_read, s1_address, s1_burstcount,
        output m_waitrequest, m_readdata, m_readdatavalid,
        input  s0_waitrequest, s0_readdata, s0_readdatavalid,
        input  s1_waitrequest, s1_readdata, s1_readdatavalid,
        input  m_address, m_burstcount, m_read
    );

endinterface

// File: rtl/sdram_arb_select.sv
// Port selection for the sdram0 read arbiter (purely combinational).
//   s0_read, s1_read : pending requests
//   consec_cnt       : port-0 grants made in a row while port 1 waited
//   sel              : chosen port (0 or 1)
// Port 0 wins by default; port 1 wins when port 0 is not asking, or when
// port 0 has used up its consecutive-grant allowance while port 1 waits.
module sdram_arb_select #(
    parameter int MAX_CONSEC = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                 s0_read,
    input  logic                 s1_read,
    input  logic [CNT_WIDTH-1:0] consec_cnt,
    output logic                 sel
);

    always_comb begin
        sel = 1'b0;
        if (!s0_read || (s1_read && consec_cnt == CNT_WIDTH'(MAX_CONSEC))) begin
            sel = 1'b1;
        end
    end

endmodule

// File: rtl/sdram_read_arbiter.sv
// Two-port read arbiter in front of the sdram0 Avalon read port.
// One master burst is outstanding at a time; return data is steered to the
// owning port by gating readdatavalid only.
//   clock, reset_n  : sole clock, asynchronous active-low reset
//   bus             : requester ports s0/s1 and sdram0 master (slave modport)
//   owner           : port of the current/last grant
//   busy            : FSM not idle
//   protocol_error  : sticky; stray readdatavalid or zero-length acceptance
module sdram_read_arbiter #(
    parameter int ADDR_WIDTH  = rush3d_sdram_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH  = rush3d_sdram_pkg::DATA_WIDTH,
    parameter int BURST_WIDTH = rush3d_sdram_pkg::BURST_WIDTH,
    parameter int MAX_CONSEC  = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    sdram_read_arbiter_if.slave  bus,
    output logic                 owner,
    output logic                 busy,
    output logic                 protocol_error
);
    import rush3d_sdram_pkg::*;

    localparam int CNT_WIDTH = $clog2(MAX_CONSEC + 1);

    arb_state_t             state, state_next;
    logic [CNT_WIDTH-1:0]   consec_cnt;
    logic [BURST_WIDTH-1:0] beat_cnt;
    logic                   owner_q;
    logic                   m_read_q;
    logic [ADDR_WIDTH-1:0]  m_address_q;
    logic [BURST_WIDTH-1:0] m_burstcount_q;
    logic                   error_q;
    // Set by reset, cleared by the first clock after release: masks beats
    // from a burst that was cut off by reset.
    logic                   rst_guard;

    logic                   sel;
    logic                   any_read;
    logic [BURST_WIDTH-1:0] sel_burst;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic                   grant, accept, beat, ack0, ack1;
    logic [DATA_WIDTH-1:0]  rd_data;

    sdram_arb_select #(
        .MAX_CONSEC (MAX_CONSEC),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_select (
        .s0_read    (bus.s0_read),
        .s1_read    (bus.s1_read),
        .consec_cnt (consec_cnt),
        .sel        (sel)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        accept     = 1'b0;
        beat       = 1'b0;
        ack0       = 1'b0;
        ack1       = 1'b0;
        any_read   = bus.s0_read | bus.s1_read;
        sel_burst  = sel ? bus.s1_burstcount : bus.s0_burstcount;
        sel_addr   = sel ? bus.s1_address : bus.s0_address;
        case (state)
            IDLE: begin
                if (any_read) begin
                    if (sel_burst == '0) begin
                        // Zero-length request: acknowledge in place, no master read.
                        ack0 = ~sel;
                        ack1 = sel;
                    end else begin
                        grant      = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!bus.m_waitrequest) begin
                    accept     = 1'b1;
                    ack0       = ~owner_q;
                    ack1       = owner_q;
                    state_next = (m_burstcount_q == '0) ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bus.m_readdatavalid) begin
                    beat = 1'b1;
                    if (beat_cnt <= BURST_WIDTH'(1)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            consec_cnt     <= '0;
            beat_cnt       <= '0;
            owner_q        <= 1'b0;
            m_read_q       <= 1'b0;
            m_address_q    <= '0;
            m_burstcount_q <= '0;
            error_q        <= 1'b0;
            rst_guard      <= 1'b1;
        end else begin
            rst_guard <= 1'b0;
            if (grant) begin
                m_read_q       <= 1'b1;
                m_address_q    <= sel_addr;
                m_burstcount_q <= sel_burst;
                owner_q        <= sel;
                if (!sel && bus.s1_read) begin
                    if (consec_cnt != CNT_WIDTH'(MAX_CONSEC)) begin
                        consec_cnt <= consec_cnt + CNT_WIDTH'(1);
                    end
                end else begin
                    consec_cnt <= '0;
                end
            end
            if (accept) begin
                m_read_q <= 1'b0;
                beat_cnt <= m_burstcount_q;
            end
            if (beat) begin
                beat_cnt <= beat_cnt - BURST_WIDTH'(1);
            end
            if ((bus.m_readdatavalid && state != DATA && !rst_guard) ||
                (accept && m_burstcount_q == '0)) begin
                error_q <= 1'b1;
            end
        end
    end

    // Acks are gated by reset_n so waitrequest reads 1 while reset is held.
    assign bus.s0_waitrequest   = ~(ack0 & reset_n);
    assign bus.s1_waitrequest   = ~(ack1 & reset_n);

    assign rd_data              = bus.m_readdata;
    assign bus.s0_readdata      = rd_data;
    assign bus.s1_readdata      = rd_data;
    assign bus.s0_readdatavalid = (state == DATA) & ~owner_q & bus.m_readdatavalid;
    assign bus.s1_readdatavalid = (state == DATA) &  owner_q & bus.m_readdatavalid;

    assign bus.m_read           = m_read_q;
    assign bus.m_address        = m_address_q;
    assign bus.m_burstcount     = m_burstcount_q;

    assign owner                = owner_q;
    assign busy                 = (state != IDLE);
    assign protocol_error       = error_q;

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Directed self-checking bench for sdram_read_arbiter.
module tb_sdram_read_arbiter;

    logic clock;
    logic reset_n;
    logic owner;
    logic busy;
    logic protocol_error;

    int unsigned checks = 0;
    int unsigned errors = 0;

    sdram_read_arbiter_if #(
        .ADDR_WIDTH  (29),
        .DATA_WIDTH  (64),
        .BURST_WIDTH (8)
    ) bus ();

    sdram_read_arbiter #(
        .ADDR_WIDTH  (29),
        .DATA_WIDTH  (64),
        .BURST_WIDTH (8),
        .MAX_CONSEC  (4)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .bus            (bus),
        .owner          (owner),
        .busy           (busy),
        .protocol_error (protocol_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ck(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n              = 1'b0;
        bus.s0_read          = 1'b1;
        bus.s0_address       = '0;
        bus.s0_burstcount    = '0;
        bus.s1_read          = 1'b0;
        bus.s1_address       = '0;
        bus.s1_burstcount    = '0;
        bus.m_waitrequest    = 1'b0;
        bus.m_readdata       = '0;
        bus.m_readdatavalid  = 1'b0;

        // Reset state, with a zero-burst request pending that must not be acked.
        #2;
        ck("rst_m_read", bus.m_read, 0);
        ck("rst_m_address", bus.m_address, 0);
        ck("rst_m_burstcount", bus.m_burstcount, 0);
        ck("rst_s0_wait", bus.s0_waitrequest, 1);
        ck("rst_s1_wait", bus.s1_waitrequest, 1);
        ck("rst_owner", owner, 0);
        ck("rst_busy", busy, 0);
        ck("rst_perr", protocol_error, 0);
        @(negedge clock);
        bus.s0_read = 1'b0;
        reset_n     = 1'b1;

        // Port 1 alone, addr 0x100, burst 8.
        tick();
        bus.s1_read       = 1'b1;
        bus.s1_address    = 29'h100;
        bus.s1_burstcount = 8'd8;
        #1;
        ck("a_idle_s1_wait", bus.s1_waitrequest, 1);
        ck("a_idle_m_read", bus.m_read, 0);
        tick();
        ck("a_issue_m_read", bus.m_read, 1);
        ck("a_issue_addr", bus.m_address, 64'h100);
        ck("a_issue_burst", bus.m_burstcount, 8);
        ck("a_issue_owner", owner, 1);
        ck("a_issue_s1_wait", bus.s1_waitrequest, 0);
        ck("a_issue_s0_wait", bus.s0_waitrequest, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.s1_read         = 1'b0;
            bus.m_readdatavalid = 1'b1;
            bus.m_readdata      = 64'hA0 + 64'(i);
            #1;
            ck("a_data_m_read", bus.m_read, 0);
            ck("a_s1_rdv", bus.s1_readdatavalid, 1);
            ck("a_s0_rdv", bus.s0_readdatavalid, 0);
            ck("a_s1_data", bus.s1_readdata, 64'hA0 + 64'(i));
            ck("a_s1_wait", bus.s1_waitrequest, 1);
        end
        tick();
        bus.m_readdatavalid = 1'b0;
        #1;
        ck("a_end_busy", busy, 0);
        ck("a_end_s1_rdv", bus.s1_readdatavalid, 0);
        ck("a_end_perr", protocol_error, 0);

        // Port 0 zero-length request.
        tick();
        bus.s0_read       = 1'b1;
        bus.s0_burstcount = 8'd0;
        #1;
        ck("z_s0_wait", bus.s0_waitrequest, 0);
        ck("z_s1_wait", bus.s1_waitrequest, 1);
        tick();
        bus.s0_read = 1'b0;
        #1;
        ck("z_m_read", bus.m_read, 0);
        ck("z_busy", busy, 0);
        ck("z_s0_wait_after", bus.s0_waitrequest, 1);

        // Master stalls 10 cycles in ISSUE.
        tick();
        bus.s0_read         = 1'b1;
        bus.s0_address      = 29'h1234;
        bus.s0_burstcount   = 8'd2;
        bus.m_waitrequest   = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            ck("w_m_read", bus.m_read, 1);
            ck("w_addr", bus.m_address, 64'h1234);
            ck("w_burst", bus.m_burstcount, 2);
            ck("w_s0_wait", bus.s0_waitrequest, 1);
            tick();
        end
        bus.m_waitrequest = 1'b0;
        #1;
        ck("w_accept_s0_wait", bus.s0_waitrequest, 0);
        ck("w_accept_m_read", bus.m_read, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            bus.s0_read         = 1'b0;
            bus.m_readdatavalid = 1'b1;
            bus.m_readdata      = 64'h5500 + 64'(i);
            #1;
            ck("w_s0_rdv", bus.s0_readdatavalid, 1);
            ck("w_s1_rdv", bus.s1_readdatavalid, 0);
            ck("w_s0_data", bus.s0_readdata, 64'h5500 + 64'(i));
        end
        tick();
        bus.m_readdatavalid = 1'b0;
        #1;
        ck("w_end_busy", busy, 0);

        // Both ports continuous, burst 4: grants 0,0,0,0,1 repeating.
        tick();
        bus.s0_read       = 1'b1;
        bus.s0_address    = 29'h200;
        bus.s0_burstcount = 8'd4;
        bus.s1_read       = 1'b1;
        bus.s1_address    = 29'h300;
        bus.s1_burstcount = 8'd4;
        for (int b = 0; b < 10; b++) begin
            tick();
            ck("f_owner", owner, (b % 5 == 4) ? 64'd1 : 64'd0);
            ck("f_addr", bus.m_address, (b % 5 == 4) ? 64'h300 : 64'h200);
            ck("f_s1_wait", bus.s1_waitrequest, (b % 5 == 4) ? 64'd0 : 64'd1);
            for (int j = 0; j < 4; j++) begin
                tick();
                bus.m_readdatavalid = 1'b1;
            end
            tick();
            bus.m_readdatavalid = 1'b0;
        end
        bus.s0_read = 1'b0;
        bus.s1_read = 1'b0;
        tick();
        ck("f_end_busy", busy, 0);
        ck("f_end_perr", protocol_error, 0);

        // Reset mid-burst after 3 of 8 beats.
        bus.s0_read       = 1'b1;
        bus.s0_address    = 29'h40;
        bus.s0_burstcount = 8'd8;
        tick();
        ck("r_issue_m_read", bus.m_read, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.s0_read         = 1'b0;
            bus.m_readdatavalid = 1'b1;
        end
        tick();
        #1;
        reset_n = 1'b0;
        #1;
        ck("r_m_read", bus.m_read, 0);
        ck("r_m_address", bus.m_address, 0);
        ck("r_m_burst", bus.m_burstcount, 0);
        ck("r_s0_wait", bus.s0_waitrequest, 1);
        ck("r_s1_wait", bus.s1_waitrequest, 1);
        ck("r_s0_rdv", bus.s0_readdatavalid, 0);
        ck("r_s1_rdv", bus.s1_readdatavalid, 0);
        ck("r_owner", owner, 0);
        ck("r_busy", busy, 0);
        ck("r_perr", protocol_error, 0);
        #2;
        reset_n = 1'b1;
        tick();
        bus.m_readdatavalid = 1'b0;
        bus.s0_read         = 1'b1;
        bus.s0_address      = 29'h80;
        bus.s0_burstcount   = 8'd1;
        #1;
        ck("r_stray_perr", protocol_error, 0);
        tick();
        ck("r2_m_read", bus.m_read, 1);
        ck("r2_addr", bus.m_address, 64'h80);
        ck("r2_owner", owner, 0);
        ck("r2_s0_wait", bus.s0_waitrequest, 0);
        tick();
        bus.s0_read         = 1'b0;
        bus.m_readdatavalid = 1'b1;
        #1;
        ck("r2_s0_rdv", bus.s0_readdatavalid, 1);
        tick();
        bus.m_readdatavalid = 1'b0;
        #1;
        ck("r2_end_busy", busy, 0);

        // Stray beat while idle.
        tick();
        bus.m_readdatavalid = 1'b1;
        #1;
        ck("e_s0_rdv", bus.s0_readdatavalid, 0);
        ck("e_s1_rdv", bus.s1_readdatavalid, 0);
        ck("e_perr_before", protocol_error, 0);
        tick();
        bus.m_readdatavalid = 1'b0;
        ck("e_perr_set", protocol_error, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            ck("e_perr_sticky", protocol_error, 1);
        end
        reset_n = 1'b0;
        #1;
        ck("e_perr_reset", protocol_error, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
